// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch front end: default widths,
// the NOP encoding shown when nothing is buffered, and the FSM state type.
package instr_fetch_pkg;

   localparam int          IF_XLEN      = 32;
   localparam logic [31:0] IF_RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] IF_NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_FLUSH = 2'b10
   } fetch_state_e;

   // True when the low address bits do not describe a word boundary.
   function automatic logic is_misaligned(input logic [1:0] lo_bits);
      return (lo_bits != 2'b00);
   endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Synchronous FIFO with a flush input, used both for the {pc, instr}
// prefetch buffer and for the queue of PCs of requests still in flight.
// DEPTH must be a power of two so the pointers wrap naturally.
module instr_fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             full_s;
   logic             empty_s;
   logic             push_ok_s;
   logic             pop_ok_s;

   // Status flags and guarded push/pop; a push into a full FIFO is refused.
   always_comb begin
      full_s    = (count_r == CW'(DEPTH));
      empty_s   = (count_r == {CW{1'b0}});
      push_ok_s = push & ~full_s;
      pop_ok_s  = pop & ~empty_s;
   end

   // Storage, pointers and occupancy; flush empties the FIFO in one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else if (flush) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Head of FIFO and status presented to the owner.
   always_comb begin
      pop_data = mem_r[rd_ptr_r];
      full     = full_s;
      empty    = empty_s;
      count    = count_r;
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end. Drives the PC, issues word requests to
// instruction memory under a credit limit, buffers returned words with their
// PCs and presents the FIFO head to decode. A redirect flushes everything and
// any responses still in flight are counted down and dropped in FLUSH.
// Optional feature: INSTR_FETCH_ALIGN_CHECK_EN adds fetch_misalign_o, a sticky
// flag set by a misaligned redirect target that halts fetch until the next
// redirect. Without it the low two target bits are forced to zero.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int              XLEN       = IF_XLEN,
   parameter logic [XLEN-1:0] RESET_PC   = XLEN'(IF_RESET_PC),
   parameter int              FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             imem_req_o,
   output logic [XLEN-1:0]  imem_addr_o,
   input  logic             imem_gnt_i,
   input  logic             imem_rvalid_i,
   input  logic [31:0]      imem_rdata_i,
   input  logic             redirect_i,
   input  logic [XLEN-1:0]  redirect_pc_i,
   output logic             instr_valid_o,
   output logic [31:0]      instr_o,
   output logic [XLEN-1:0]  instr_pc_o,
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
   output logic             fetch_misalign_o,
`endif
   input  logic             instr_ready_i
);

   localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
   localparam int            DW      = XLEN + 32;
   localparam logic [CW:0]   DEPTH_W = (CW + 1)'(FIFO_DEPTH);

   fetch_state_e     state_r;
   fetch_state_e     state_nxt_s;
   logic [XLEN-1:0]  pc_r;
   logic [CW-1:0]    discard_r;
   logic [XLEN-1:0]  redirect_pc_s;
   logic             halt_s;
   logic             req_s;
   logic             credit_ok_s;
   logic             gnt_take_s;
   logic             rsp_hit_s;
   logic             rsp_take_s;
   logic             drop_s;
   logic             pop_s;

   logic [XLEN-1:0]  pq_data_s;
   logic             pq_full_s;
   logic             pq_empty_s;
   logic [CW-1:0]    pq_count_s;

   logic [DW-1:0]    dq_data_s;
   logic             dq_full_s;
   logic             dq_empty_s;
   logic [CW-1:0]    dq_count_s;
   logic             dq_push_s;

`ifdef INSTR_FETCH_ALIGN_CHECK_EN
   logic             misalign_r;

   // Redirect target taken as given; its alignment is judged by the flag.
   always_comb begin
      redirect_pc_s = redirect_pc_i;
      halt_s        = misalign_r;
   end

   // Sticky misalignment flag, re-evaluated on every redirect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misalign_r <= 1'b0;
      end else if (redirect_i) begin
         misalign_r <= is_misaligned(redirect_pc_i[1:0]);
      end else begin
         misalign_r <= misalign_r;
      end
   end

   // Export the flag.
   always_comb begin
      fetch_misalign_o = misalign_r;
   end
`else
   // Redirect target forced to a word boundary; fetch never halts.
   always_comb begin
      redirect_pc_s = redirect_pc_i & {{(XLEN-2){1'b1}}, 2'b00};
      halt_s        = 1'b0;
   end
`endif

   // Handshake qualifiers shared by the FSM and the datapath.
   always_comb begin
      credit_ok_s = (({1'b0, dq_count_s} + {1'b0, pq_count_s}) < DEPTH_W);
      gnt_take_s  = req_s & imem_gnt_i;
      rsp_hit_s   = imem_rvalid_i & ~pq_empty_s;
      rsp_take_s  = (state_r == ST_RUN) & ~redirect_i & rsp_hit_s;
      drop_s      = (state_r == ST_FLUSH) & imem_rvalid_i & (discard_r != {CW{1'b0}});
      dq_push_s   = rsp_take_s & ~dq_full_s;
      pop_s       = ~dq_empty_s & instr_ready_i;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next state and request generation.
   always_comb begin
      state_nxt_s = state_r;
      req_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            state_nxt_s = ST_RUN;
         end
         ST_RUN: begin
            if (redirect_i && !pq_empty_s) begin
               state_nxt_s = ST_FLUSH;
            end else begin
               state_nxt_s = ST_RUN;
            end
            if (!redirect_i && credit_ok_s && !halt_s && !pq_full_s) begin
               req_s = 1'b1;
            end else begin
               req_s = 1'b0;
            end
         end
         ST_FLUSH: begin
            if ((discard_r == {CW{1'b0}}) || (drop_s && (discard_r == CW'(1)))) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_FLUSH;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Fetch PC: redirect wins, otherwise advance one word per grant (wraps).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r <= RESET_PC;
      end else if (redirect_i) begin
         pc_r <= redirect_pc_s;
      end else if (gnt_take_s) begin
         pc_r <= pc_r + XLEN'(4);
      end else begin
         pc_r <= pc_r;
      end
   end

   // Responses still owed when a redirect hits RUN; counted down in FLUSH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         discard_r <= {CW{1'b0}};
      end else if (redirect_i && (state_r == ST_RUN)) begin
         discard_r <= pq_count_s - {{(CW-1){1'b0}}, rsp_hit_s};
      end else if (drop_s) begin
         discard_r <= discard_r - CW'(1);
      end else begin
         discard_r <= discard_r;
      end
   end

   // PCs of granted requests, matched in order against responses.
   instr_fetch_fifo #(
      .WIDTH (XLEN),
      .DEPTH (FIFO_DEPTH)
   ) u_pcq (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_i),
      .push      (gnt_take_s),
      .push_data (pc_r),
      .pop       (rsp_take_s),
      .pop_data  (pq_data_s),
      .full      (pq_full_s),
      .empty     (pq_empty_s),
      .count     (pq_count_s)
   );

   // Prefetch buffer of {pc, instr} entries.
   instr_fetch_fifo #(
      .WIDTH (DW),
      .DEPTH (FIFO_DEPTH)
   ) u_dq (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_i),
      .push      (dq_push_s),
      .push_data ({pq_data_s, imem_rdata_i}),
      .pop       (pop_s),
      .pop_data  (dq_data_s),
      .full      (dq_full_s),
      .empty     (dq_empty_s),
      .count     (dq_count_s)
   );

   // Memory request and decode-facing outputs; NOP/0 shown while empty.
   always_comb begin
      imem_req_o    = req_s;
      imem_addr_o   = pc_r;
      instr_valid_o = ~dq_empty_s;
      if (dq_empty_s) begin
         instr_o    = IF_NOP_INSTR;
         instr_pc_o = {XLEN{1'b0}};
      end else begin
         instr_o    = dq_data_s[31:0];
         instr_pc_o = dq_data_s[DW-1:32];
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural instruction memory whose
// word at address a is a ^ 32'h5A5A_0000, so data can be tied to its PC.
module tb_instr_fetch;

   logic        clk;
   logic        rst_n;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        ready;
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
   logic        misalign;
`endif

   logic        rsp_en;
   logic        stray;
   logic [31:0] pend_q[$];
   int          gnt_cnt;
   int          n_vec;
   int          n_err;
   int          span;
   int          k;
   int          cyc;

   instr_fetch dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .imem_req_o       (imem_req_o),
      .imem_addr_o      (imem_addr_o),
      .imem_gnt_i       (gnt),
      .imem_rvalid_i    (rvalid),
      .imem_rdata_i     (rdata),
      .redirect_i       (redirect),
      .redirect_pc_i    (redirect_pc),
      .instr_valid_o    (instr_valid_o),
      .instr_o          (instr_o),
      .instr_pc_o       (instr_pc_o),
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
      .fetch_misalign_o (misalign),
`endif
      .instr_ready_i    (ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Memory: grants sampled mid-cycle, responses in order one cycle later.
   initial begin
      rvalid  = 1'b0;
      rdata   = 32'h0;
      gnt_cnt = 0;
      forever begin
         @(negedge clk);
         if (rst_n && imem_req_o && gnt) begin
            pend_q.push_back(imem_addr_o);
            gnt_cnt++;
         end
         @(posedge clk);
         #1;
         if (!rst_n) begin
            pend_q.delete();
            gnt_cnt = 0;
            rvalid  = 1'b0;
         end else if (stray) begin
            rvalid = 1'b1;
            rdata  = 32'hDEAD_BEEF;
         end else if (rsp_en && pend_q.size() > 0) begin
            rvalid = 1'b1;
            rdata  = mem_word(pend_q.pop_front());
         end else begin
            rvalid = 1'b0;
         end
      end
   end

   // Consume n instructions, checking PC order and data; bounded by budget.
   task automatic drain_expect(input string tag, input logic [31:0] start_pc,
                               input int n, input int budget, output int sp);
      logic [31:0] e;
      int got;
      int first;
      int c;
      e = start_pc; got = 0; first = -1; c = 0; sp = 0;
      while (got < n && c < budget) begin
         @(negedge clk);
         c++;
         if (instr_valid_o && ready) begin
            chk({tag, "_pc"}, instr_pc_o, e);
            chk({tag, "_data"}, instr_o, mem_word(e));
            if (first < 0) first = c;
            sp = c - first;
            e = e + 32'd4;
            got++;
         end
      end
      if (got < n) chk({tag, "_timeout"}, got, n);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec = 0; n_err = 0;
      rst_n = 1'b0; gnt = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      ready = 1'b0; rsp_en = 1'b1; stray = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req", imem_req_o, 1'b0);
      chk("rst_valid", instr_valid_o, 1'b0);
      chk("rst_instr", instr_o, 32'h0000_0013);
      chk("rst_pc", instr_pc_o, 32'h0);
      chk("rst_addr", imem_addr_o, 32'h0);
      rst_n = 1'b1; gnt = 1'b1; ready = 1'b1;

      // 1: zero-wait stream, one instruction per cycle
      drain_expect("t1", 32'h0, 8, 40, span);
      chk("t1_span", span, 7);

      // 2: decode stalls; four entries held, req drops, drains in order
      @(posedge clk); #1 ready = 1'b0;
      repeat (10) @(negedge clk);
      chk("t2_req", imem_req_o, 1'b0);
      chk("t2_valid", instr_valid_o, 1'b1);
      chk("t2_head", instr_pc_o, 32'h20);
      chk("t2_held", gnt_cnt - 8, 4);
      @(posedge clk); #1 ready = 1'b1;
      drain_expect("t2", 32'h20, 8, 40, span);

      // 3: three requests in flight, redirect to 0x100
      @(posedge clk); #1 gnt = 1'b0;
      repeat (12) @(negedge clk);
      rsp_en = 1'b0;
      @(posedge clk); #1 gnt = 1'b1;
      k = 0; cyc = 0;
      while (k < 3 && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (imem_req_o) k++;
      end
      chk("t3_issued", k, 3);
      @(posedge clk); #1 gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
      @(negedge clk);
      chk("t3_req_redir", imem_req_o, 1'b0);
      rsp_en = 1'b1;
      @(posedge clk); #1 redirect = 1'b0; gnt = 1'b1;
      @(negedge clk);
      chk("t3_req_flush", imem_req_o, 1'b0);
      drain_expect("t3", 32'h100, 4, 60, span);

      // 4: redirect in the same cycle as a pop
      @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'h300;
      @(negedge clk);
      chk("t4_valid_redir", instr_valid_o, 1'b1);
      chk("t4_req_redir", imem_req_o, 1'b0);
      @(posedge clk); #1 redirect = 1'b0;
      @(negedge clk);
      chk("t4_no_stale", instr_valid_o, 1'b0);
      drain_expect("t4", 32'h300, 3, 60, span);

      // 5: PC wrap at the top of the address space
      @(posedge clk); #1 gnt = 1'b0;
      repeat (10) @(negedge clk);
      @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      @(posedge clk); #1 redirect = 1'b0; gnt = 1'b1;
      @(negedge clk);
      chk("t5_req", imem_req_o, 1'b1);
      chk("t5_addr_top", imem_addr_o, 32'hFFFF_FFFC);
      @(negedge clk);
      chk("t5_addr_wrap", imem_addr_o, 32'h0);
      drain_expect("t5", 32'hFFFF_FFFC, 4, 40, span);

`ifdef INSTR_FETCH_ALIGN_CHECK_EN
      // 6: misaligned redirect halts fetch until an aligned redirect
      @(posedge clk); #1 gnt = 1'b0;
      repeat (10) @(negedge clk);
      @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'h102;
      @(posedge clk); #1 redirect = 1'b0; gnt = 1'b1;
      @(negedge clk);
      chk("t6_flag_set", misalign, 1'b1);
      chk("t6_req_halt", imem_req_o, 1'b0);
      repeat (3) @(negedge clk);
      chk("t6_still_halt", imem_req_o, 1'b0);
      chk("t6_no_valid", instr_valid_o, 1'b0);
      @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'h200;
      @(posedge clk); #1 redirect = 1'b0;
      @(negedge clk);
      chk("t6_flag_clr", misalign, 1'b0);
      chk("t6_req_resume", imem_req_o, 1'b1);
      chk("t6_addr", imem_addr_o, 32'h200);
      drain_expect("t6", 32'h200, 3, 40, span);
`endif

      // 7: asynchronous reset mid-stream, then a stray response is ignored
      @(posedge clk); #1 rst_n = 1'b0;
      #1;
      chk("t7_req", imem_req_o, 1'b0);
      chk("t7_valid", instr_valid_o, 1'b0);
      chk("t7_instr", instr_o, 32'h0000_0013);
      chk("t7_pc", instr_pc_o, 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1; gnt = 1'b0; stray = 1'b1;
      @(negedge clk);
      stray = 1'b0;
      repeat (3) @(negedge clk);
      chk("t7_stray_ignored", instr_valid_o, 1'b0);
      chk("t7_addr", imem_addr_o, 32'h0);
      gnt = 1'b1;
      drain_expect("t7", 32'h0, 3, 40, span);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
